// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV64I multicycle control unit: FSM states, opcode
// classes, ALU operation codes, splice codes and ALUSrcB selects.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_IRLOAD, S_DECODE, S_EXEC_R, S_EXEC_I, S_ADDR, S_LD_MEM,
        S_LD_MDR, S_LD_WB, S_ST_MEM, S_ALU_WB, S_BRANCH, S_PC_INC, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_SYSTEM, CLS_NONE
    } op_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [1:0] SPLICE_D = 2'b00;
    localparam logic [1:0] SPLICE_W = 2'b01;
    localparam logic [1:0] SPLICE_H = 2'b10;
    localparam logic [1:0] SPLICE_B = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_FOUR = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;
    localparam logic [1:0] SRCB_BOFF = 2'd3;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_source;
        logic       alu_src_a;
        logic       load_aout;
        logic       reg_write;
        logic       load_reg_a;
        logic       load_reg_b;
        logic       mem_to_reg;
        logic       dmem_op;
        logic       load_mdr;
        logic       ir_write;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] load_splice;
        logic [1:0] store_splice;
    } ctrl_flags_t;

    function automatic op_class_t classify(input logic [6:0] opcode);
        case (opcode)
            OP_R:      return CLS_R;
            OP_IMM:    return CLS_I;
            OP_LOAD:   return CLS_LOAD;
            OP_STORE:  return CLS_STORE;
            OP_BRANCH: return CLS_BRANCH;
            OP_SYSTEM: return CLS_SYSTEM;
            default:   return CLS_NONE;
        endcase
    endfunction

    // Only funct3 values 000..011 reach a memory state; others halt in decode.
    function automatic logic [1:0] splice_code(input logic [2:0] funct3);
        case (funct3)
            3'b011:  return SPLICE_D;
            3'b010:  return SPLICE_W;
            3'b001:  return SPLICE_H;
            default: return SPLICE_B;
        endcase
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation decode and legality check for R, I, load/store
// and branch classes; system-class legality is resolved by the caller.
module alu_op_decode
    import ctrl_pkg::*;
(
    input  op_class_t  op_class,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_op,
    output logic       legal
);

    logic [3:0] f3_op;
    logic       f3_ok;

    always_comb begin
        f3_op = ALU_ADD;
        f3_ok = 1'b1;
        case (funct3)
            3'b000:  f3_op = ALU_ADD;
            3'b111:  f3_op = ALU_AND;
            3'b110:  f3_op = ALU_OR;
            3'b100:  f3_op = ALU_XOR;
            3'b010:  f3_op = ALU_SLT;
            default: f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b0;
        case (op_class)
            CLS_R: begin
                alu_op = (funct7 == 7'h20) ? ALU_SUB : f3_op;
                legal  = ((funct7 == 7'h00) && f3_ok) ||
                         ((funct7 == 7'h20) && (funct3 == 3'b000));
            end
            CLS_I: begin
                alu_op = f3_op;
                legal  = f3_ok;
            end
            // Unsigned loads (lbu/lhu/lwu) are outside the supported set.
            CLS_LOAD, CLS_STORE: legal = ~funct3[2];
            CLS_BRANCH: begin
                alu_op = ALU_SUB;
                legal  = (funct3[2:1] == 2'b00);
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle control FSM for the RV64I datapath. Optional performance counters
// are built only when CTRL_PERF_CNT_EN is defined; otherwise they read 0.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instruction,
    input  logic             alu_zero,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             PCSource,
    output logic             ALUSrcA,
    output logic             LoadAOut,
    output logic             RegWrite,
    output logic             LoadRegA,
    output logic             LoadRegB,
    output logic             MemToReg,
    output logic             DMemOp,
    output logic             LoadMDR,
    output logic             IMemRead,
    output logic             IRWrite,
    output logic [1:0]       ALUSrcB,
    output logic [3:0]       ALUOp,
    output logic [1:0]       LoadSplice,
    output logic [1:0]       StoreSplice,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_t      state, ns;
    ctrl_flags_t flags_r, flags_ns;
    logic        bne_arm_r, bne_arm_ns;
    logic        halted_r, illegal_r;

    op_class_t   op_class;
    logic [3:0]  dec_alu_op;
    logic        dec_legal, decode_ok, is_bne, branch_taken;

    assign op_class     = classify(instruction[6:0]);
    assign decode_ok    = (op_class == CLS_SYSTEM) ? (instruction == INSN_EBREAK) : dec_legal;
    assign is_bne       = instruction[12];
    assign branch_taken = is_bne ? ~alu_zero : alu_zero;

    alu_op_decode u_alu_op_decode (
        .op_class (op_class),
        .funct3   (instruction[14:12]),
        .funct7   (instruction[31:25]),
        .alu_op   (dec_alu_op),
        .legal    (dec_legal)
    );

    function automatic ctrl_flags_t pc_inc(input ctrl_flags_t f);
        ctrl_flags_t r = f;
        r.alu_src_a = 1'b0;
        r.alu_src_b = SRCB_FOUR;
        r.alu_op    = ALU_ADD;
        r.pc_source = 1'b0;
        r.pc_write  = 1'b1;
        r.load_aout = 1'b0;
        return r;
    endfunction

    // Flags are registered from the next state so each state's outputs are flop-driven.
    always_comb begin
        ns         = state;
        flags_ns   = '0;
        bne_arm_ns = 1'b0;
        case (state)
            S_FETCH:  ns = S_IRLOAD;
            S_IRLOAD: ns = S_DECODE;
            S_DECODE: begin
                if (!decode_ok) ns = S_HALT;
                else begin
                    case (op_class)
                        CLS_R:               ns = S_EXEC_R;
                        CLS_I:               ns = S_EXEC_I;
                        CLS_LOAD, CLS_STORE: ns = S_ADDR;
                        CLS_BRANCH:          ns = S_BRANCH;
                        default:             ns = S_HALT;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I:                   ns = S_ALU_WB;
            S_ADDR:   ns = (op_class == CLS_LOAD) ? S_LD_MEM : S_ST_MEM;
            S_LD_MEM:                             ns = S_LD_MDR;
            S_LD_MDR:                             ns = S_LD_WB;
            S_LD_WB, S_ALU_WB, S_ST_MEM, S_PC_INC: ns = S_FETCH;
            S_BRANCH: ns = branch_taken ? S_FETCH : S_PC_INC;
            default:                              ns = S_HALT;
        endcase

        case (ns)
            S_IRLOAD: flags_ns.ir_write = 1'b1;
            S_DECODE: begin
                flags_ns.load_reg_a = 1'b1;
                flags_ns.load_reg_b = 1'b1;
                flags_ns.alu_src_b  = SRCB_BOFF;
                flags_ns.alu_op     = ALU_ADD;
                flags_ns.load_aout  = 1'b1;
            end
            S_EXEC_R, S_EXEC_I, S_ADDR: begin
                flags_ns.alu_src_a = 1'b1;
                flags_ns.alu_src_b = (ns == S_EXEC_R) ? SRCB_REG : SRCB_IMM;
                flags_ns.alu_op    = (ns == S_ADDR) ? ALU_ADD : dec_alu_op;
                flags_ns.load_aout = 1'b1;
            end
            S_LD_MDR: flags_ns.load_mdr = 1'b1;
            S_LD_WB: begin
                flags_ns             = pc_inc(flags_ns);
                flags_ns.reg_write   = 1'b1;
                flags_ns.mem_to_reg  = 1'b1;
                flags_ns.load_splice = splice_code(instruction[14:12]);
            end
            S_ALU_WB: begin
                flags_ns           = pc_inc(flags_ns);
                flags_ns.reg_write = 1'b1;
            end
            S_ST_MEM: begin
                flags_ns              = pc_inc(flags_ns);
                flags_ns.dmem_op      = 1'b1;
                flags_ns.store_splice = splice_code(instruction[14:12]);
            end
            S_PC_INC: flags_ns = pc_inc(flags_ns);
            S_BRANCH: begin
                flags_ns.alu_src_a     = 1'b1;
                flags_ns.alu_src_b     = SRCB_REG;
                flags_ns.alu_op        = ALU_SUB;
                flags_ns.pc_source     = 1'b1;
                flags_ns.pc_write_cond = ~is_bne;
                bne_arm_ns             = is_bne;
            end
            default: flags_ns = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_FETCH;
            flags_r   <= '0;
            bne_arm_r <= 1'b0;
            halted_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            state     <= ns;
            flags_r   <= flags_ns;
            bne_arm_r <= bne_arm_ns;
            if (ns == S_HALT) halted_r <= 1'b1;
            if (state == S_DECODE && !decode_ok) illegal_r <= 1'b1;
        end
    end

    // bne writes the PC only when the subtract result is non-zero in the branch cycle.
    assign PCWrite     = flags_r.pc_write | (bne_arm_r & ~alu_zero);
    assign PCWriteCond = flags_r.pc_write_cond;
    assign PCSource    = flags_r.pc_source;
    assign ALUSrcA     = flags_r.alu_src_a;
    assign LoadAOut    = flags_r.load_aout;
    assign RegWrite    = flags_r.reg_write;
    assign LoadRegA    = flags_r.load_reg_a;
    assign LoadRegB    = flags_r.load_reg_b;
    assign MemToReg    = flags_r.mem_to_reg;
    assign DMemOp      = flags_r.dmem_op;
    assign LoadMDR     = flags_r.load_mdr;
    assign IRWrite     = flags_r.ir_write;
    assign ALUSrcB     = flags_r.alu_src_b;
    assign ALUOp       = flags_r.alu_op;
    assign LoadSplice  = flags_r.load_splice;
    assign StoreSplice = flags_r.store_splice;
    assign halted      = halted_r;
    assign illegal     = illegal_r;
    // Reset parks the FSM in fetch; gating keeps the read strobe low while reset is held.
    assign IMemRead    = reset & (state == S_FETCH);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, instret_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (!halted_r) cycle_q <= cycle_q + CNT_W'(1);
            if (ns == S_FETCH) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: a per-instruction cycle-trace model feeds
// a queue that a single compare process checks against the DUT every cycle.
module tb_control_fsm;

    localparam int CNT_W = 32;
`ifdef CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [31:0] instruction = '0;
    logic alu_zero = 1'b0;
    logic PCWrite, PCWriteCond, PCSource, ALUSrcA, LoadAOut, RegWrite, LoadRegA, LoadRegB;
    logic MemToReg, DMemOp, LoadMDR, IMemRead, IRWrite, halted, illegal;
    logic [1:0] ALUSrcB, LoadSplice, StoreSplice;
    logic [3:0] ALUOp;
    logic [CNT_W-1:0] cycle_cnt, instret_cnt;

    control_fsm #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instruction(instruction), .alu_zero(alu_zero),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .ALUSrcA(ALUSrcA),
        .LoadAOut(LoadAOut), .RegWrite(RegWrite), .LoadRegA(LoadRegA), .LoadRegB(LoadRegB),
        .MemToReg(MemToReg), .DMemOp(DMemOp), .LoadMDR(LoadMDR), .IMemRead(IMemRead),
        .IRWrite(IRWrite), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .LoadSplice(LoadSplice),
        .StoreSplice(StoreSplice), .halted(halted), .illegal(illegal),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic pc_write, pc_write_cond, pc_source, alu_src_a, load_aout, reg_write;
        logic load_reg_a, load_reg_b, mem_to_reg, dmem_op, load_mdr, imem_read, ir_write;
        logic [1:0] alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] load_splice, store_splice;
        logic halted, illegal;
    } obs_t;

    typedef struct {
        obs_t o;
        bit   retire;
    } rec_t;

    rec_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    m_cyc = 0;
    int    m_ret = 0;
    string cur_name = "reset";

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic obs_t get_obs();
        obs_t o;
        o.pc_write = PCWrite;     o.pc_write_cond = PCWriteCond; o.pc_source = PCSource;
        o.alu_src_a = ALUSrcA;    o.load_aout = LoadAOut;        o.reg_write = RegWrite;
        o.load_reg_a = LoadRegA;  o.load_reg_b = LoadRegB;       o.mem_to_reg = MemToReg;
        o.dmem_op = DMemOp;       o.load_mdr = LoadMDR;          o.imem_read = IMemRead;
        o.ir_write = IRWrite;     o.alu_src_b = ALUSrcB;         o.alu_op = ALUOp;
        o.load_splice = LoadSplice; o.store_splice = StoreSplice;
        o.halted = halted;        o.illegal = illegal;
        return o;
    endfunction

    function automatic void push(input obs_t o, input bit ret);
        rec_t r;
        r.o = o;
        r.retire = ret;
        exp_q.push_back(r);
    endfunction

    // ALU operation table for the funct3-selected ops (add/and/or/xor/slt).
    function automatic logic [3:0] alu_of_f3(input logic [2:0] f3, output bit ok);
        ok = 1'b1;
        case (f3)
            3'd0:    return 4'd0;
            3'd7:    return 4'd2;
            3'd6:    return 4'd3;
            3'd4:    return 4'd4;
            3'd2:    return 4'd5;
            default: begin ok = 1'b0; return 4'd0; end
        endcase
    endfunction

    // Expected per-cycle outputs of one instruction, from fetch until it retires or halts.
    task automatic model_instr(input logic [31:0] ins, input logic az, output int len);
        obs_t o, inc, ex;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        logic [3:0] op;
        logic [1:0] spl;
        bit ok, brk, taken;
        int n0;
        n0  = exp_q.size();
        opc = ins[6:0];
        f3  = ins[14:12];
        f7  = ins[31:25];
        spl = 2'(3 - int'(f3));
        ok  = 1'b0;
        brk = 1'b0;
        op  = 4'd0;
        o = '0; o.imem_read = 1'b1; push(o, 1'b0);
        o = '0; o.ir_write = 1'b1;  push(o, 1'b0);
        o = '0; o.load_reg_a = 1'b1; o.load_reg_b = 1'b1; o.alu_src_b = 2'd3; o.load_aout = 1'b1;
        push(o, 1'b0);
        inc = '0; inc.alu_src_b = 2'd1; inc.pc_write = 1'b1;
        ex  = '0; ex.alu_src_a = 1'b1; ex.alu_src_b = 2'd2; ex.load_aout = 1'b1;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00) op = alu_of_f3(f3, ok);
                else if (f7 == 7'h20 && f3 == 3'd0) begin op = 4'd1; ok = 1'b1; end
            end
            7'h13: op = alu_of_f3(f3, ok);
            7'h03, 7'h23: ok = (f3 <= 3'd3);
            7'h63: ok = (f3 <= 3'd1);
            7'h73: begin ok = (ins == 32'h0010_0073); brk = ok; end
            default: ok = 1'b0;
        endcase
        if (!ok || brk) begin
            o = '0; o.halted = 1'b1; o.illegal = !ok;
            repeat (3) push(o, 1'b0);
        end else begin
            case (opc)
                7'h33, 7'h13: begin
                    o = ex; o.alu_op = op;
                    if (opc == 7'h33) o.alu_src_b = 2'd0;
                    push(o, 1'b0);
                    o = inc; o.reg_write = 1'b1; push(o, 1'b1);
                end
                7'h03: begin
                    push(ex, 1'b0);
                    push('0, 1'b0);
                    o = '0; o.load_mdr = 1'b1; push(o, 1'b0);
                    o = inc; o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.load_splice = spl;
                    push(o, 1'b1);
                end
                7'h23: begin
                    push(ex, 1'b0);
                    o = inc; o.dmem_op = 1'b1; o.store_splice = spl; push(o, 1'b1);
                end
                default: begin
                    taken = (f3 == 3'd0) ? az : !az;
                    o = '0; o.alu_src_a = 1'b1; o.alu_op = 4'd1; o.pc_source = 1'b1;
                    if (f3 == 3'd0) o.pc_write_cond = 1'b1;
                    else o.pc_write = !az;
                    push(o, taken);
                    if (!taken) push(inc, 1'b1);
                end
            endcase
        end
        len = exp_q.size() - n0;
    endtask

    // Single compare process: one queued expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            rec_t r;
            r = exp_q.pop_front();
            chk({cur_name, "_flags"}, 64'(get_obs()), 64'(r.o));
            chk({cur_name, "_cycle_cnt"}, 64'(cycle_cnt), PERF ? 64'(m_cyc) : 64'd0);
            chk({cur_name, "_instret_cnt"}, 64'(instret_cnt), PERF ? 64'(m_ret) : 64'd0);
            if (!r.o.halted) m_cyc++;
            if (r.retire) m_ret++;
        end
    end

    task automatic start(input string nm, input logic [31:0] ins, input logic az, input int exp_len);
        int len;
        instruction = ins;
        alu_zero    = az;
        cur_name    = nm;
        model_instr(ins, az, len);
        chk({"len_", nm}, 64'(len), 64'(exp_len));
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk({cur_name, "_drain_timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        #1;
    endtask

    task automatic run(input string nm, input logic [31:0] ins, input logic az, input int exp_len);
        start(nm, ins, az, exp_len);
        drain();
    endtask

    task automatic do_reset(input string nm);
        reset = 1'b0;
        #1;
        chk({nm, "_async_clear"}, 64'(get_obs()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        chk({nm, "_held"}, 64'(get_obs()), 64'd0);
        chk({nm, "_cnt_zero"}, 64'({cycle_cnt, instret_cnt}), 64'd0);
        reset = 1'b1;
        m_cyc = 0;
        m_ret = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_flags", 64'(get_obs()), 64'd0);
        chk("reset_counters", 64'({cycle_cnt, instret_cnt}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        start("add", 32'h0020_81B3, 1'b1, 5);
        chk("pin_add_aluop", 64'(exp_q[3].o.alu_op), 64'h0);
        chk("pin_add_wb", 64'({exp_q[4].o.reg_write, exp_q[4].o.pc_write, exp_q[4].o.mem_to_reg}), 64'b110);
        drain();
        start("sub", 32'h4020_81B3, 1'b0, 5);
        chk("pin_sub_aluop", 64'(exp_q[3].o.alu_op), 64'b0001);
        drain();
        run("and",  32'h0020_F1B3, 1'b0, 5);
        run("or",   32'h0020_E1B3, 1'b0, 5);
        run("xor",  32'h0020_C1B3, 1'b0, 5);
        run("slt",  32'h0020_A1B3, 1'b0, 5);
        run("addi", 32'h0050_8093, 1'b0, 5);
        run("andi", 32'h0050_F093, 1'b1, 5);
        run("ori",  32'h0050_E093, 1'b0, 5);
        run("xori", 32'h0050_C093, 1'b0, 5);
        run("slti", 32'h0050_A093, 1'b0, 5);
        start("ld", 32'h0080_B283, 1'b0, 7);
        chk("pin_ld_mdr_cycle6", 64'(exp_q[5].o.load_mdr), 64'd1);
        chk("pin_ld_wb", 64'({exp_q[6].o.mem_to_reg, exp_q[6].o.load_splice}), 64'b100);
        drain();
        run("lw", 32'h0080_A283, 1'b0, 7);
        run("lh", 32'h0080_9283, 1'b0, 7);
        run("lb", 32'h0080_8283, 1'b1, 7);
        start("sb", 32'h0020_8023, 1'b0, 5);
        chk("pin_sb", 64'({exp_q[4].o.dmem_op, exp_q[4].o.store_splice, exp_q[4].o.pc_write}), 64'b1111);
        drain();
        run("sh", 32'h0020_9023, 1'b0, 5);
        run("sw", 32'h0020_A023, 1'b0, 5);
        run("sd", 32'h0020_B023, 1'b1, 5);
        start("beq_taken", 32'h0020_8463, 1'b1, 4);
        chk("pin_beq", 64'({exp_q[3].o.pc_write_cond, exp_q[3].o.pc_source}), 64'b11);
        drain();
        run("beq_not_taken", 32'h0020_8463, 1'b0, 5);
        start("bne_not_taken", 32'h0020_9463, 1'b1, 5);
        chk("pin_bne_nt_pcwrite", 64'(exp_q[3].o.pc_write), 64'd0);
        drain();
        run("bne_taken", 32'h0020_9463, 1'b0, 4);

        run("sub_f7_01", 32'h0220_81B3, 1'b0, 6);
        chk("sub_f7_01_sticky", 64'({halted, illegal}), 64'b11);
        do_reset("rst_after_illegal");
        run("lbu", 32'h0080_C283, 1'b0, 6);
        do_reset("rst_after_lbu");
        run("slli", 32'h0050_9093, 1'b0, 6);
        do_reset("rst_after_slli");
        run("ebreak", 32'h0010_0073, 1'b0, 6);
        chk("ebreak_sticky", 64'({halted, illegal}), 64'b10);
        do_reset("rst_after_ebreak");
        run("add_after_halt", 32'h0020_81B3, 1'b0, 5);

        // Reset asserted in the middle of a load, while the MDR is being loaded.
        cur_name    = "ld_abort";
        instruction = 32'h0080_B283;
        repeat (5) @(posedge clk);
        #2;
        chk("ld_abort_mdr_before_reset", 64'(LoadMDR), 64'd1);
        do_reset("ld_abort");
        run("add_after_abort", 32'h0020_81B3, 1'b0, 5);
        run("bne_after_abort", 32'h0020_9463, 1'b1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
